// File: rtl/openhw_fetchalign_if.sv
// Fetch-side and decode-side signals of the fetch-alignment buffer, plus redirect and occupancy.
// The slave modport is the buffer's view. The master modport is the view of whatever drives it.
interface openhw_fetchalign_if #(
  parameter int XLEN      = 64,
  parameter int FETCHBITS = 64,
  parameter int QDEPTH    = 16
);
  logic                     FlushD;
  logic [XLEN-1:0]          FlushPC;
  logic                     FetchValid;
  logic                     FetchReady;
  logic [FETCHBITS-1:0]     FetchData;
  logic                     FetchFault;
  logic                     InstrValid;
  logic                     InstrReady;
  logic [31:0]              InstrRaw;
  logic                     CompressedF;
  logic                     InstrFault;
  logic [XLEN-1:0]          InstrPC;
  logic [$clog2(QDEPTH):0]  Count;

  modport master (
    output FlushD, FlushPC, FetchValid, FetchData, FetchFault, InstrReady,
    input  FetchReady, InstrValid, InstrRaw, CompressedF, InstrFault, InstrPC, Count
  );

  modport slave (
    input  FlushD, FlushPC, FetchValid, FetchData, FetchFault, InstrReady,
    output FetchReady, InstrValid, InstrRaw, CompressedF, InstrFault, InstrPC, Count
  );
endinterface

// File: rtl/openhw_fetchalign.sv
// Halfword queue that realigns fetch blocks into one 16/32-bit instruction per cycle. A block accepted at edge N is visible in cycle N+1.
// FetchReady drops when fewer than one block of free slots remain, or a fault is pending. Decode stalls through InstrReady.
module openhw_fetchalign #(
  parameter int XLEN      = 64,
  parameter int FETCHBITS = 64,
  parameter int QDEPTH    = 16
) (
  input logic                clk,
  input logic                reset,
  openhw_fetchalign_if.slave bus
);
  localparam int H  = FETCHBITS / 16;
  localparam int HW = $clog2(H);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] QD = (PW+1)'(QDEPTH);
  localparam logic [PW:0] HC = (PW+1)'(H);
  localparam logic [PW:0] C1 = (PW+1)'(1);
  localparam logic [PW:0] C2 = (PW+1)'(2);

  logic [15:0]     r_q [QDEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;
  logic [XLEN-1:0] r_pc;
  logic [HW-1:0]   r_drop;
  logic            r_fault;

  logic [PW-1:0]   w_head1;
  logic [15:0]     w_h0;
  logic [15:0]     w_h1;
  logic            w_is32;
  logic            w_cvalid;
  logic            w_ready;
  logic            w_pop;
  logic            w_acc;
  logic            w_push;
  logic [PW:0]     w_pop_n;
  logic [PW:0]     w_push_n;
  logic [31:0]     w_raw;

  assign w_head1 = r_head + PW'(1);
  assign w_h0    = r_q[r_head];
  assign w_h1    = r_q[w_head1];
  assign w_is32  = (w_h0[1:0] == 2'b11);
  // A 32-bit head with only one halfword held waits for its second block.
  assign w_cvalid = w_is32 ? (r_count >= C2) : (r_count != '0);
  assign w_ready  = !r_fault && ((QD - r_count) >= HC);

  assign w_pop    = w_cvalid && bus.InstrReady && !bus.FlushD;
  assign w_pop_n  = !w_pop ? '0 : (w_is32 ? C2 : C1);
  assign w_acc    = bus.FetchValid && w_ready && !bus.FlushD;
  assign w_push   = w_acc && !bus.FetchFault;
  assign w_push_n = w_push ? (HC - (PW+1)'(r_drop)) : '0;

  assign w_raw = !w_cvalid ? 32'h0 : (w_is32 ? {w_h1, w_h0} : {16'h0, w_h0});

  assign bus.FetchReady  = w_ready;
  assign bus.InstrValid  = w_cvalid || r_fault;
  assign bus.InstrFault  = !w_cvalid && r_fault;
  assign bus.InstrRaw    = w_raw;
  assign bus.CompressedF = (w_raw[1:0] != 2'b11);
  assign bus.InstrPC     = r_pc;
  assign bus.Count       = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pc    <= '0;
      r_drop  <= '0;
      r_fault <= 1'b0;
    end else if (bus.FlushD) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pc    <= bus.FlushPC;
      r_drop  <= bus.FlushPC[HW:1];
      r_fault <= 1'b0;
    end else begin
      r_head  <= r_head + PW'(w_pop_n);
      r_tail  <= r_tail + PW'(w_push_n);
      r_count <= r_count + w_push_n - w_pop_n;
      r_pc    <= r_pc + (XLEN'(w_pop_n) << 1);
      if (w_push)
        r_drop <= '0;
      // The fault stays at the head until a redirect clears it.
      if (w_acc && bus.FetchFault)
        r_fault <= 1'b1;
    end
  end

  // Storage needs no reset: Count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = 0; i < H; i++) begin
        if (HW'(i) >= r_drop)
          r_q[r_tail + PW'(i) - PW'(r_drop)] <= bus.FetchData[16*i +: 16];
      end
    end
  end
endmodule

// File: tb/tb_openhw_fetchalign.sv
// Directed bench for openhw_fetchalign with a queue-of-halfwords reference model checked every cycle.
module tb_openhw_fetchalign;
  localparam int XLEN = 64;
  localparam int FB   = 64;
  localparam int QD   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  openhw_fetchalign_if #(.XLEN(XLEN), .FETCHBITS(FB), .QDEPTH(QD)) bus ();
  openhw_fetchalign #(.XLEN(XLEN), .FETCHBITS(FB), .QDEPTH(QD)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the queue holds exactly the halfwords still to be decoded.
  logic [15:0] mq[$];
  logic [63:0] mpc    = '0;
  bit          mfault = 1'b0;
  int          mdrop  = 0;
  int          mn;
  bit          mrdy;
  bit          cmp_en  = 1'b0;
  bit          saw_i15 = 1'b0;

  function automatic int pop_n();
    if (mq.size() >= 1 && mq[0][1:0] != 2'b11) return 1;
    if (mq.size() >= 2) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] exp_raw();
    int n;
    n = pop_n();
    if (n == 1) return {16'h0, mq[0]};
    if (n == 2) return {mq[1], mq[0]};
    return 32'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mpc    = '0;
      mfault = 1'b0;
      mdrop  = 0;
    end else if (bus.FlushD) begin
      mq.delete();
      mpc    = bus.FlushPC;
      mfault = 1'b0;
      mdrop  = int'(bus.FlushPC[2:1]);
    end else begin
      mrdy = !mfault && (QD - mq.size() >= 4);
      mn   = pop_n();
      if (bus.InstrReady && mn > 0) begin
        repeat (mn) void'(mq.pop_front());
        mpc = mpc + 64'(2 * mn);
      end
      if (bus.FetchValid && mrdy) begin
        if (bus.FetchFault) mfault = 1'b1;
        else begin
          for (int i = mdrop; i < 4; i++) mq.push_back(bus.FetchData[16*i +: 16]);
          mdrop = 0;
        end
      end
    end
  end

  int          cn;
  logic [31:0] craw;
  bit          cval;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      cn   = pop_n();
      cval = (cn > 0) || mfault;
      craw = exp_raw();
      chk("m_valid", bus.InstrValid, cval);
      chk("m_fault", bus.InstrFault, (cn == 0) && mfault);
      chk("m_count", bus.Count, mq.size());
      chk("m_ready", bus.FetchReady, !mfault && (QD - mq.size() >= 4));
      chk("m_pc", bus.InstrPC, mpc);
      if (cval) begin
        chk("m_raw", bus.InstrRaw, craw);
        chk("m_comp", bus.CompressedF, craw[1:0] != 2'b11);
      end
      if (bus.InstrValid && bus.InstrRaw == 32'hA00F_00F3) saw_i15 = 1'b1;
    end
  end

  logic [15:0] S [36];
  function automatic logic [63:0] blk(input int b);
    return {S[4*b+3], S[4*b+2], S[4*b+1], S[4*b]};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic flush(input logic [63:0] pc);
    bus.FlushD  = 1'b1;
    bus.FlushPC = pc;
    cyc();
    bus.FlushD  = 1'b0;
  endtask

  task automatic feed(input int b);
    int t;
    bus.FetchData  = blk(b);
    bus.FetchValid = 1'b1;
    t = 0;
    while (!bus.FetchReady && t < 50) begin
      cyc();
      t++;
    end
    chk("feed_ready", bus.FetchReady, 1);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t;
    bus.FlushD = 1'b0; bus.FlushPC = '0; bus.FetchValid = 1'b0;
    bus.FetchData = '0; bus.FetchFault = 1'b0; bus.InstrReady = 1'b0;
    // 32-bit instructions Ik = {A000+k, 0003+16k}; one compressed halfword shifts I15 across the wrap.
    for (int k = 0; k < 8; k++) begin
      S[2*k]   = 16'h0003 + 16'(16 * k);
      S[2*k+1] = 16'hA000 + 16'(k);
    end
    S[16] = 16'h0001;
    for (int k = 8; k < 16; k++) begin
      S[17 + 2*(k-8)] = 16'h0003 + 16'(16 * k);
      S[18 + 2*(k-8)] = 16'hA000 + 16'(k);
    end
    for (int k = 33; k < 36; k++) S[k] = 16'h0001;

    repeat (2) cyc();
    chk("rst_count", bus.Count, 0);
    chk("rst_valid", bus.InstrValid, 0);
    chk("rst_fault", bus.InstrFault, 0);
    chk("rst_raw", bus.InstrRaw, 0);
    chk("rst_comp", bus.CompressedF, 1);
    chk("rst_ready", bus.FetchReady, 1);
    chk("rst_pc", bus.InstrPC, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Basic decode right after a flush.
    bus.InstrReady = 1'b1;
    flush(64'h1000);
    bus.FetchValid = 1'b1; bus.FetchData = 64'h0000_0013_0001_0001;
    cyc();
    bus.FetchValid = 1'b0;
    chk("t2_valid0", bus.InstrValid, 1);
    chk("t2_raw0", bus.InstrRaw, 32'h0001);
    chk("t2_comp0", bus.CompressedF, 1);
    chk("t2_pc0", bus.InstrPC, 64'h1000);
    chk("t2_count0", bus.Count, 4);
    cyc();
    chk("t2_raw1", bus.InstrRaw, 32'h0001);
    chk("t2_pc1", bus.InstrPC, 64'h1002);
    cyc();
    chk("t2_raw2", bus.InstrRaw, 32'h0000_0013);
    chk("t2_comp2", bus.CompressedF, 0);
    chk("t2_pc2", bus.InstrPC, 64'h1004);
    cyc();
    chk("t2_count_end", bus.Count, 0);
    chk("t2_valid_end", bus.InstrValid, 0);

    // Instruction split across two blocks.
    flush(64'h1006);
    bus.FetchValid = 1'b1; bus.FetchData = 64'h0013_0000_0000_0000;
    cyc();
    chk("t3_count_spill", bus.Count, 1);
    chk("t3_valid_spill", bus.InstrValid, 0);
    bus.FetchData = 64'h0001_0001_0001_0000;
    cyc();
    bus.FetchValid = 1'b0;
    chk("t3_raw", bus.InstrRaw, 32'h0000_0013);
    chk("t3_comp", bus.CompressedF, 0);
    chk("t3_pc", bus.InstrPC, 64'h1006);
    cyc();
    chk("t3_pc_next", bus.InstrPC, 64'h100A);
    chk("t3_count_next", bus.Count, 3);

    // Fill to capacity, partial drain, then wrap.
    bus.InstrReady = 1'b0;
    flush(64'h3000);
    for (int b = 0; b < 4; b++) begin
      bus.FetchValid = 1'b1; bus.FetchData = blk(b);
      cyc();
    end
    chk("t4_count_full", bus.Count, 16);
    chk("t4_ready_full", bus.FetchReady, 0);
    chk("t4_raw_i0", bus.InstrRaw, 32'hA000_0003);
    bus.FetchData = blk(4); bus.InstrReady = 1'b1;
    cyc();
    chk("t4_count14", bus.Count, 14);
    chk("t4_ready14", bus.FetchReady, 0);
    chk("t4_pc14", bus.InstrPC, 64'h3004);
    cyc();
    chk("t4_count12", bus.Count, 12);
    chk("t4_ready12", bus.FetchReady, 1);
    bus.InstrReady = 1'b0;
    cyc();
    chk("t4_count_refill", bus.Count, 16);
    bus.InstrReady = 1'b1;
    for (int b = 5; b < 9; b++) feed(b);
    bus.FetchValid = 1'b0;
    t = 0;
    while (bus.Count != 0 && t < 100) begin
      cyc();
      t++;
    end
    chk("t4_drained", bus.Count, 0);
    chk("t4_pc_end", bus.InstrPC, 64'h3048);
    chk("t4_wrap_i15", saw_i15, 1);

    // Fault delivered after the preceding instructions.
    bus.InstrReady = 1'b0;
    flush(64'h2000);
    bus.FetchValid = 1'b1; bus.FetchData = 64'h0001_0001_0001_0001;
    cyc();
    bus.FetchFault = 1'b1;
    cyc();
    bus.FetchValid = 1'b0; bus.FetchFault = 1'b0;
    chk("t5_ready_pend", bus.FetchReady, 0);
    chk("t5_fault_early", bus.InstrFault, 0);
    chk("t5_count", bus.Count, 4);
    bus.InstrReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_raw", bus.InstrRaw, 32'h0001);
      chk("t5_pc", bus.InstrPC, 64'h2000 + 64'(2 * k));
      cyc();
    end
    chk("t5_fault", bus.InstrFault, 1);
    chk("t5_fvalid", bus.InstrValid, 1);
    chk("t5_fpc", bus.InstrPC, 64'h2008);
    chk("t5_fraw", bus.InstrRaw, 0);
    cyc();
    chk("t5_fault_held", bus.InstrFault, 1);
    chk("t5_ready_held", bus.FetchReady, 0);

    // Flush wins over a same-cycle push and pop.
    bus.InstrReady = 1'b0;
    flush(64'h4000);
    bus.FetchValid = 1'b1; bus.FetchData = 64'h0001_0001_0001_0001;
    cyc();
    chk("t6_count_pre", bus.Count, 4);
    bus.FlushD = 1'b1; bus.FlushPC = 64'h5000; bus.InstrReady = 1'b1;
    cyc();
    bus.FlushD = 1'b0; bus.FetchValid = 1'b0;
    chk("t6_count", bus.Count, 0);
    chk("t6_pc", bus.InstrPC, 64'h5000);
    chk("t6_valid", bus.InstrValid, 0);
    chk("t6_ready", bus.FetchReady, 1);

    // Asynchronous reset mid-stream.
    bus.InstrReady = 1'b0;
    flush(64'h6004);
    bus.FetchValid = 1'b1; bus.FetchData = 64'h0001_0001_0001_0001;
    cyc();
    cyc();
    bus.FetchValid = 1'b0;
    chk("t1_count_pre", bus.Count, 6);
    #2 rst = 1'b1;
    #1;
    chk("t1_count", bus.Count, 0);
    chk("t1_valid", bus.InstrValid, 0);
    chk("t1_ready", bus.FetchReady, 1);
    chk("t1_pc", bus.InstrPC, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("t1_count_after", bus.Count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/openhw_fetchalign.md
# openhw_fetchalign

Parametrised fetch-alignment buffer for the IFU. It accepts naturally aligned fetch blocks of configurable width from the I$/bus through a valid/ready handshake and queues them as halfwords. It emits one aligned 32-bit instruction per cycle, with a compressed flag and the instruction PC, to the Decode stage. Instructions that straddle a block or cache-line boundary are merged in the queue without a second fetch request, and fetch faults are delivered in program order.

## Interface
Parameters:
- XLEN, 64, PC width.
- FETCHBITS, 64, fetch block width; one of 32, 64, 128. H = FETCHBITS/16 halfwords per block.
- QDEPTH, 16, queue depth in halfwords; power of 2, at least 2*H.

Ports (reset is asynchronous, active-high):
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- FlushD  in  1  redirect: discard queue contents and restart at FlushPC.
- FlushPC  in  XLEN  new PC, 2-byte aligned; bits [log2(FETCHBITS/8)-1:1] give the start halfword within the first block.
- FetchValid  in  1  FetchData or FetchFault is valid.
- FetchReady  out  1  buffer can accept a block.
- FetchData  in  FETCHBITS  aligned block; halfword i occupies bits [16i+15:16i].
- FetchFault  in  1  block is an access or page fault; its data is ignored.
- InstrValid  out  1  InstrRaw/InstrFault valid.
- InstrReady  in  1  Decode accepts (~StallD).
- InstrRaw  out  32  instruction; upper half is 0 when compressed.
- CompressedF  out  1  InstrRaw[1:0] != 2'b11.
- InstrFault  out  1  entry is a fault marker.
- InstrPC  out  XLEN  PC of the emitted instruction.
- Count  out  log2(QDEPTH)+1  halfwords held.

## Operation
- Circular halfword queue with head and tail pointers modulo QDEPTH and a Count register.
- DropCnt register is loaded from the FlushPC offset on flush. The first block accepted after a flush writes only halfwords DropCnt..H-1, then DropCnt clears. Later blocks write all H halfwords.
- FetchReady = ~FaultPending & (QDEPTH - Count >= H). Count here is the current value and ignores any same-cycle pop.
- Head decode:
  - Count >= 1 and head[1:0] != 11: compressed. InstrRaw = {16'h0, head}. Pop 1; PC += 2.
  - head[1:0] == 11 and Count >= 2: InstrRaw = {head+1, head}. Pop 2; PC += 4.
  - head[1:0] == 11 and Count == 1: spill wait, InstrValid = 0. This is not an error.
- Fault handling:
  - An accepted FetchFault sets FaultPending and writes nothing.
  - When FaultPending is set and no complete instruction is at the head (Count == 0 or spill wait), output InstrValid = 1, InstrFault = 1, InstrRaw = 0, and InstrPC = current PC.
  - Faults are therefore delivered in order. FaultPending is held until flush, and the fault entry is never popped.
- Push and pop may occur in the same cycle: Count += pushed - popped, with no bubble.
- FlushD has priority over push, pop and fault. It clears the pointers, Count and FaultPending, loads PC = FlushPC and DropCnt, and ignores any same-cycle FetchValid and InstrReady.
- Pointer wrap: a multi-halfword push or pop wraps modulo QDEPTH, and a 32-bit instruction may span slots QDEPTH-1 and 0.

## Timing
- Reset values: Count 0, head/tail 0, PC 0, DropCnt 0, FaultPending 0, InstrValid 0, InstrFault 0, InstrRaw 0, CompressedF 1, FetchReady 1.
- All outputs are combinational from registered state. There is no path from FetchValid/FetchData to any output in the same cycle.
- Latency: a block accepted at edge N gives InstrValid in cycle N+1.
- After a flush at edge N, the first block can be accepted in cycle N+1.
- A spilled instruction becomes valid the cycle after its second block is accepted.
- Throughput: one instruction per cycle while data is available.
- Reset may be asserted mid-operation. Its effect is immediate and asynchronous, and all state returns to reset values.

## Test plan
Parameters for all scenarios: FETCHBITS=64, QDEPTH=16.
- Reset mid-stream with Count=6 -> Count=0, InstrValid=0, FetchReady=1 immediately.
- Flush 0x1000, block 0x0000_0013_0001_0001 -> cycle+1: 0x0001 compressed, PC 0x1000. Then 0x0001 compressed at 0x1002, then 0x00000013 at 0x1004. Count reaches 0.
- Spill: flush 0x1006, block with halfword3 = 0x0013 -> Count=1, InstrValid=0. Next block with halfword0 = 0x0000 -> InstrRaw=0x00000013, CompressedF=0, InstrPC=0x1006; next PC 0x100A.
- Full: InstrReady=0 with blocks streamed -> FetchReady=0 once Count=16. Pop one 32-bit instruction -> FetchReady stays 0 (free=2 < 4). After a pop to Count=12 -> FetchReady=1. Contents are correct across the pointer wrap.
- Fault: flush 0x2000, block of four 0x0001 then FetchFault -> four compressed instructions, then InstrFault=1 at PC 0x2008, FetchReady=0 until a flush.
- Flush with FetchValid and InstrReady in the same cycle -> block dropped, no pop, Count=0, PC=FlushPC.
